// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback stage.
// Opcodes, instruction fields, FSM states and decode helpers.
package alu_issue_ctrl_pkg;

  localparam int DW    = 8;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  localparam logic [3:0] OP_INV = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_SLA = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ADD = 4'd9;
  localparam logic [3:0] OP_SUB = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_LDI = 4'd12;
  localparam logic [3:0] OP_NOP = 4'd13;

  localparam int F_OP_HI  = 15;
  localparam int F_OP_LO  = 12;
  localparam int F_RD_HI  = 11;
  localparam int F_RD_LO  = 9;
  localparam int F_RS1_HI = 8;
  localparam int F_RS1_LO = 6;
  localparam int F_RS2_HI = 5;
  localparam int F_RS2_LO = 3;
  localparam int F_IMM_HI = 7;
  localparam int F_IMM_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_WB_HI = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [DW-1:0] imm;
  } inflight_t;

  function automatic logic op_is_alu(
    input logic [3:0] op
  );
    return op < OP_MUL;
  endfunction

  function automatic logic op_is_illegal(
    input logic [3:0] op
  );
    return op > OP_NOP;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// 8x8 register file: one write port, three
// combinational read ports, synchronous clear.
module alu_issue_ctrl_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
  input  logic [AW-1:0] ra3,
  output logic [DW-1:0] rd3
);

  logic [DW-1:0] mem_q [NREGS];
  logic [DW-1:0] mem_d [NREGS];

  // Next-state storage: single-entry update.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage flops, cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!rst_n) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];
  assign rd3 = mem_q[ra3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage for the 8-bit ALU:
// one instruction in flight, registered ALU operands.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic [15:0]   alu_product,
  input  logic          alu_of,
  input  logic          alu_zero,
  input  logic          alu_slt,
  output logic          flag_of,
  output logic          flag_zero,
  output logic          flag_slt,
  output logic          done,
  output logic          illegal,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [3:0]    op_q, op_d;
  inflight_t     inf_q, inf_d;
  logic [2:0]    flags_q, flags_d;
  logic          done_q, done_d;
  logic          ill_q, ill_d;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;

  alu_issue_ctrl_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .ra1   (instr[F_RS1_HI:F_RS1_LO]),
    .rd1   (rs1_data),
    .ra2   (instr[F_RS2_HI:F_RS2_LO]),
    .rd2   (rs2_data),
    .ra3   (dbg_addr),
    .rd3   (dbg_data)
  );

  // FSM next state, operand capture and writeback.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    inf_d    = inf_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = inf_q.rd;
    rf_wdata = alu_result;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          a_d       = rs1_data;
          b_d       = rs2_data;
          op_d      = instr[F_OP_HI:F_OP_LO];
          inf_d.op  = instr[F_OP_HI:F_OP_LO];
          inf_d.rd  = instr[F_RD_HI:F_RD_LO];
          inf_d.imm = instr[F_IMM_HI:F_IMM_LO];
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        if (inf_q.op != OP_MUL) begin
          done_d = 1'b1;
          ill_d  = op_is_illegal(inf_q.op);
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        unique case (1'b1)
          op_is_alu(inf_q.op): begin
            rf_we   = 1'b1;
            flags_d = {alu_of, alu_zero, alu_slt};
          end
          (inf_q.op == OP_MUL): begin
            rf_we    = 1'b1;
            rf_wdata = alu_product[7:0];
            flags_d  = {alu_of, alu_zero, alu_slt};
            done_d   = 1'b1;
            state_d  = S_WB_HI;
          end
          (inf_q.op == OP_LDI): begin
            rf_we    = 1'b1;
            rf_wdata = inf_q.imm;
          end
          default: ;
        endcase
      end
      S_WB_HI: begin
        rf_we    = 1'b1;
        rf_waddr = inf_q.rd + 3'd1;
        rf_wdata = alu_product[15:8];
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      inf_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      inf_q   <= inf_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign flag_of     = flags_q[2];
  assign flag_zero   = flags_q[1];
  assign flag_slt    = flags_q[0];
  assign done        = done_q;
  assign illegal     = ill_q;

endmodule
